// File: rtl/exmem_skid_stage.sv
// EX->MEM elastic stage: 2-entry skid (main + skid) with flush and a stall counter.
// Latency: 1 cycle from accept to out_* when downstream is not stalling.
// Backpressure: in_ready is registered and drops only when both entries are full.
module exmem_skid_stage #(
  parameter int DATA_W             = 101,
  parameter int CTRL_W             = 7,
  parameter int CNT_W              = 16,
  parameter int ZERO_DATA_ON_FLUSH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state, state_n;

  logic              in_ready_q;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic accept, drain;
  logic ld_main_in, ld_main_skid, ld_skid, clr_skid, clr_main_ctrl;

  assign out_valid = (state != S_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;

  // Next-state and register load enables; flush overrides every transition.
  always_comb begin
    state_n       = state;
    ld_main_in    = 1'b0;
    ld_main_skid  = 1'b0;
    ld_skid       = 1'b0;
    clr_skid      = 1'b0;
    clr_main_ctrl = 1'b0;
    if (flush) begin
      state_n = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (accept) begin
            ld_main_in = 1'b1;
            state_n    = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            ld_main_in = 1'b1;
          end else if (accept) begin
            ld_skid = 1'b1;
            state_n = S_FULL;
          end else if (drain) begin
            clr_main_ctrl = 1'b1;
            state_n       = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so nothing can be accepted
          if (drain) begin
            ld_main_skid = 1'b1;
            clr_skid     = 1'b1;
            state_n      = S_ONE;
          end
        end
        default: state_n = S_EMPTY;
      endcase
    end
  end

  // State register plus the registered ready, which tracks the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != S_FULL);
    end
  end

  // Main register: control is zeroed whenever it holds a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      main_ctrl <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      if (ZERO_DATA_ON_FLUSH != 0) main_data <= '0;
    end else if (ld_main_in) begin
      main_data <= in_data;
      main_ctrl <= in_ctrl;
    end else if (ld_main_skid) begin
      main_data <= skid_data;
      main_ctrl <= skid_ctrl;
    end else if (clr_main_ctrl) begin
      main_ctrl <= '0;
    end
  end

  // Skid register: absorbs the word accepted while downstream is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      skid_ctrl <= '0;
      if (ZERO_DATA_ON_FLUSH != 0) skid_data <= '0;
    end else if (ld_skid) begin
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
    end else if (clr_skid) begin
      skid_data <= '0;
      skid_ctrl <= '0;
    end
  end

  // Saturating stall counter; clear beats increment, flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
